if_stage: RTL

- Instruction-fetch stage of the MIPS32 pipeline, directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned instruction word into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump redirect, exception vectoring, stall and flush.

---
 rtl/if_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage -- MIPS32 instruction-fetch stage.
//
// Owns the program counter, presents it to the combinational instruction
// ROM and captures the returned word into the IF/ID pipeline register.
// It handles sequential fetch, branch/jump redirect, exception vectoring,
// stall and flush.
//
// Ports:
//   clk             pipeline clock, rising-edge active
//   reset           asynchronous, active-low reset
//   stall           hold PC and IF/ID
//   flush           replace IF/ID with a bubble on the next edge
//   redirect_valid  taken branch/jump, target on redirect_pc
//   redirect_pc     redirect target (used verbatim, no alignment check)
//   exc_req         exception/interrupt accepted, vector to EXC_VECTOR
//   rom_addr        ROM address (equal to the current PC)
//   rom_data        ROM instruction word, valid in the same cycle
//   if_id_pc        PC of the instruction held in IF/ID
//   if_id_pc_plus4  sequential successor of if_id_pc
//   if_id_instr     instruction held in IF/ID
//   if_id_valid     1 = real instruction, 0 = bubble
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;

  // Bit 31 is the supervisor flag: an increment never touches it, and the
  // carry out of bit 30 is dropped so the low half wraps within its mode.
  function automatic logic [31:0] inc_pc(input logic [31:0] pc);
    inc_pc = {pc[31], pc[30:0] + 31'd4};
  endfunction

  // ---- stage p0: fetch (PC drives the ROM directly) ----
  assign rom_addr    = pc_p0;
  assign pc_plus4_p0 = inc_pc(pc_p0);

  // ---- stage p1: IF/ID register ----
  // A bubble only rewrites instr/valid; if_id_pc and if_id_pc_plus4 keep
  // their old values because downstream EPC capture depends on them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc_p0    <= RESET_PC;
      pc_p1    <= 32'h0000_0000;
      pc4_p1   <= 32'h0000_0000;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (state == ST_BOOT) begin
      // One idle cycle so the first ROM word gets a full cycle of setup;
      // redirect and exception requests are ignored here.
      state    <= ST_RUN;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (exc_req) begin
      pc_p0    <= EXC_VECTOR;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (redirect_valid) begin
      // The word fetched this cycle is wrong-path and is dropped.
      pc_p0    <= redirect_pc;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else begin
      if (!stall) begin
        pc_p0 <= pc_plus4_p0;
      end
      // flush wins over the stall hold, but only for IF/ID.
      if (flush) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else if (!stall) begin
        pc_p1    <= pc_p0;
        pc4_p1   <= pc_plus4_p0;
        instr_p1 <= rom_data;
        vld_p1   <= 1'b1;
      end
    end
  end

  assign if_id_pc       = pc_p1;
  assign if_id_pc_plus4 = pc4_p1;
  assign if_id_instr    = instr_p1;
  assign if_id_valid    = vld_p1;

endmodule
